fp_adder_pipe_amisha: RTL and testbench

Parametrised, pipelined successor to the team's combinational sign-magnitude floating-point adder. Accepts one operand pair per cycle under a valid/ready handshake and returns the normalised sum four cycles later. Exponent and fraction widths are generic, and the block adds exponent overflow saturation, underflow flush-to-zero and optional round-to-nearest-even. It sits between operand registers and the result FIFO in the FP datapath.

---
 rtl/fp_pkg_amisha.sv | 28 ++
 rtl/fp_lzc_amisha.sv | 31 +++
 rtl/fp_adder_pipe_amisha.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_adder_pipe_amisha.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg_amisha.sv
// ---------------------------------------------------------------------------
// fp_pkg_amisha
// Shared constants for the pipelined floating-point adder:
//   GRS_W      - guard/round/sticky extension carried through align/add/normalise
//   PIPE_DEPTH - number of registered stages from acceptance to result
//   ZERO_*     - encoding used for an all-zero result (sign 0, exp 0, frac 0)
//   clog2_amisha - ceiling log2 used to size the leading-zero count
// No ports (package).
// ---------------------------------------------------------------------------
package fp_pkg_amisha;

    localparam int         GRS_W      = 3;
    localparam int         PIPE_DEPTH = 4;
    localparam logic       ZERO_SIGN  = 1'b0;
    localparam logic [63:0] ZERO_FIELD = '0;

    function automatic int clog2_amisha(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc_amisha.sv
// ---------------------------------------------------------------------------
// fp_lzc_amisha
// Purely combinational leading-zero counter.
// Ports:
//   vec_i [N-1:0]    - vector to scan, MSB first
//   lz_o  [LZ_W-1:0] - number of zeros above the first set bit (N when vec_i == 0)
// ---------------------------------------------------------------------------
module fp_lzc_amisha
    import fp_pkg_amisha::*;
#(
    parameter int N    = 11,
    parameter int LZ_W = clog2_amisha(N + 1)
) (
    input  logic [N-1:0]    vec_i,
    output logic [LZ_W-1:0] lz_o
);

    logic found;

    always_comb begin
        lz_o  = LZ_W'(N);
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && vec_i[i]) begin
                lz_o  = LZ_W'(N - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_adder_pipe_amisha.sv
// ---------------------------------------------------------------------------
// fp_adder_pipe_amisha
// Four-stage pipelined sign-magnitude floating-point adder,
// value = (-1)^s * 0.frac * 2^exp, zero encoded as exp = 0, frac = 0.
// Stages: sort -> align -> add/sub -> normalise/round/saturate.
// A single global advance (~out_valid | out_ready) stalls every stage.
// Optional feature macro: FP_ADDER_ROUND_EN selects round-to-nearest-even;
// without it the GRS bits are truncated.
// Ports:
//   clk_amisha, rst_n_amisha (async, active-low)
//   in_valid_amisha / in_ready_amisha   - operand handshake
//   sign/exp/frac 1 and 2               - operands (normalised or zero)
//   out_valid_amisha / out_ready_amisha - result handshake
//   sign/exp/frac_out_amisha            - result
//   ovf_amisha / unf_amisha             - saturated / flushed to zero
// ---------------------------------------------------------------------------
module fp_adder_pipe_amisha
    import fp_pkg_amisha::*;
#(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic              clk_amisha,
    input  logic              rst_n_amisha,
    input  logic              in_valid_amisha,
    output logic              in_ready_amisha,
    input  logic              sign1_amisha,
    input  logic              sign2_amisha,
    input  logic [EXP_W-1:0]  exp1_amisha,
    input  logic [EXP_W-1:0]  exp2_amisha,
    input  logic [FRAC_W-1:0] frac1_amisha,
    input  logic [FRAC_W-1:0] frac2_amisha,
    output logic              out_valid_amisha,
    input  logic              out_ready_amisha,
    output logic              sign_out_amisha,
    output logic [EXP_W-1:0]  exp_out_amisha,
    output logic [FRAC_W-1:0] frac_out_amisha,
    output logic              ovf_amisha,
    output logic              unf_amisha
);

    localparam int M_W  = FRAC_W + GRS_W;   // fraction + guard/round/sticky
    localparam int S_W  = M_W + 1;          // plus carry
    localparam int E1_W = EXP_W + 1;        // exponent with overflow bit
    localparam int LZ_W = clog2_amisha(M_W + 1);

    logic advance;

    logic              vld_p1_q, sign_p1_q, sub_p1_q;
    logic [EXP_W-1:0]  exp_p1_q, diff_p1_q;
    logic [FRAC_W-1:0] big_p1_q, small_p1_q;

    logic              vld_p2_q, sign_p2_q, sub_p2_q;
    logic [EXP_W-1:0]  exp_p2_q;
    logic [FRAC_W-1:0] big_p2_q;
    logic [M_W-1:0]    small_p2_q;

    logic              vld_p3_q, sign_p3_q;
    logic [EXP_W-1:0]  exp_p3_q;
    logic [S_W-1:0]    sum_p3_q;

    logic              out_valid_q, sign_q, ovf_q, unf_q;
    logic [EXP_W-1:0]  exp_q;
    logic [FRAC_W-1:0] frac_q;
    logic              sign_d, ovf_d, unf_d;
    logic [EXP_W-1:0]  exp_d;
    logic [FRAC_W-1:0] frac_d;

    logic                    op1_big;
    logic [LZ_W-1:0]         lz;
    logic [M_W-1:0]          norm_m;
    logic [E1_W-1:0]         norm_e;
    logic                    is_zero, flush;
    logic [E1_W+FRAC_W-1:0]  rnd;
    logic [EXP_W+FRAC_W:0]   sat;

    // Right shift with every bit pushed past the sticky position ORed into sticky.
    function automatic logic [M_W-1:0] align_small(input logic [FRAC_W-1:0] frac,
                                                   input logic [EXP_W-1:0]  diff);
        logic [M_W-1:0] ext, shifted;
        logic           lost;
        ext = {frac, {GRS_W{1'b0}}};
        if (int'(diff) >= M_W) begin
            shifted = '0;
            lost    = |ext;
        end else begin
            shifted = ext >> diff;
            lost    = |(ext << (M_W - int'(diff)));
        end
        return {shifted[M_W-1:1], shifted[0] | lost};
    endfunction

    // Returns {exp, frac}; a fraction carry re-normalises to 100..0 and bumps exp.
    function automatic logic [E1_W+FRAC_W-1:0] round_mant(input logic [M_W-1:0]  m,
                                                          input logic [E1_W-1:0] e);
        logic [FRAC_W-1:0] f;
        logic              inc;
        logic [FRAC_W:0]   f_inc;
        f = m[M_W-1:GRS_W];
`ifdef FP_ADDER_ROUND_EN
        inc = m[2] & (m[1] | m[0] | f[0]);
`else
        inc = 1'b0;
`endif
        f_inc = {1'b0, f} + {{FRAC_W{1'b0}}, inc};
        if (f_inc[FRAC_W]) begin
            return {e + 1'b1, 1'b1, {(FRAC_W - 1){1'b0}}};
        end
        return {e, f_inc[FRAC_W-1:0]};
    endfunction

    // Returns {ovf, exp, frac}; any exponent past all-ones pins to the largest value.
    function automatic logic [EXP_W+FRAC_W:0] saturate(input logic [E1_W-1:0]   e,
                                                       input logic [FRAC_W-1:0] f);
        if (e[EXP_W]) begin
            return {1'b1, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
        end
        return {1'b0, e[EXP_W-1:0], f};
    endfunction

    assign advance         = ~out_valid_q | out_ready_amisha;
    assign in_ready_amisha = advance;

    // Ties go to operand 1, so big - small is never negative.
    assign op1_big = {exp1_amisha, frac1_amisha} >= {exp2_amisha, frac2_amisha};

    fp_lzc_amisha #(
        .N    (M_W),
        .LZ_W (LZ_W)
    ) u_lzc (
        .vec_i (sum_p3_q[M_W-1:0]),
        .lz_o  (lz)
    );

    always_comb begin
        norm_m  = '0;
        norm_e  = '0;
        is_zero = 1'b0;
        flush   = 1'b0;
        rnd     = '0;
        sat     = '0;
        sign_d  = ZERO_SIGN;
        exp_d   = ZERO_FIELD[EXP_W-1:0];
        frac_d  = ZERO_FIELD[FRAC_W-1:0];
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (sum_p3_q[S_W-1]) begin
            norm_m = {sum_p3_q[S_W-1:2], sum_p3_q[1] | sum_p3_q[0]};
            norm_e = E1_W'(exp_p3_q) + 1'b1;
        end else if (sum_p3_q[M_W-1:0] == '0) begin
            is_zero = 1'b1;
        end else if (int'(exp_p3_q) >= int'(lz)) begin
            norm_m = sum_p3_q[M_W-1:0] << lz;
            norm_e = E1_W'(exp_p3_q) - E1_W'(lz);
        end else begin
            flush = 1'b1;
        end
        if (flush) begin
            unf_d = 1'b1;
        end else if (!is_zero) begin
            rnd    = round_mant(norm_m, norm_e);
            sat    = saturate(rnd[E1_W+FRAC_W-1:FRAC_W], rnd[FRAC_W-1:0]);
            sign_d = sign_p3_q;
            {ovf_d, exp_d, frac_d} = sat;
        end
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (advance) begin
            vld_p1_q    <= in_valid_amisha;
            vld_p2_q    <= vld_p1_q;
            vld_p3_q    <= vld_p2_q;
            // S4 -> output
            out_valid_q <= vld_p3_q;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (advance) begin
            // S1: sort
            sign_p1_q  <= op1_big ? sign1_amisha : sign2_amisha;
            sub_p1_q   <= sign1_amisha ^ sign2_amisha;
            exp_p1_q   <= op1_big ? exp1_amisha : exp2_amisha;
            diff_p1_q  <= op1_big ? (exp1_amisha - exp2_amisha) : (exp2_amisha - exp1_amisha);
            big_p1_q   <= op1_big ? frac1_amisha : frac2_amisha;
            small_p1_q <= op1_big ? frac2_amisha : frac1_amisha;
            // S2: align
            sign_p2_q  <= sign_p1_q;
            sub_p2_q   <= sub_p1_q;
            exp_p2_q   <= exp_p1_q;
            big_p2_q   <= big_p1_q;
            small_p2_q <= align_small(small_p1_q, diff_p1_q);
            // S3: add/sub
            sign_p3_q  <= sign_p2_q;
            exp_p3_q   <= exp_p2_q;
            sum_p3_q   <= sub_p2_q ? ({1'b0, big_p2_q, {GRS_W{1'b0}}} - {1'b0, small_p2_q})
                                   : ({1'b0, big_p2_q, {GRS_W{1'b0}}} + {1'b0, small_p2_q});
        end
    end

    assign out_valid_amisha = out_valid_q;
    assign sign_out_amisha  = sign_q;
    assign exp_out_amisha   = exp_q;
    assign frac_out_amisha  = frac_q;
    assign ovf_amisha       = ovf_q;
    assign unf_amisha       = unf_q;

endmodule

// File: tb/tb_fp_adder_pipe_amisha.sv
// ---------------------------------------------------------------------------
// tb_fp_adder_pipe_amisha
// Directed bench for fp_adder_pipe_amisha (EXP_W=4, FRAC_W=8). Expected values
// follow FP_ADDER_ROUND_EN when defined, truncation otherwise.
// ---------------------------------------------------------------------------
module tb_fp_adder_pipe_amisha;
    import fp_pkg_amisha::*;

    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic              sign1, sign2, sign_out, ovf, unf;
    logic [EXP_W-1:0]  exp1, exp2, exp_out;
    logic [FRAC_W-1:0] frac1, frac2, frac_out;

    always #5 clk = ~clk;

    fp_adder_pipe_amisha #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk_amisha       (clk),
        .rst_n_amisha     (rst_n),
        .in_valid_amisha  (in_valid),
        .in_ready_amisha  (in_ready),
        .sign1_amisha     (sign1),
        .sign2_amisha     (sign2),
        .exp1_amisha      (exp1),
        .exp2_amisha      (exp2),
        .frac1_amisha     (frac1),
        .frac2_amisha     (frac2),
        .out_valid_amisha (out_valid),
        .out_ready_amisha (out_ready),
        .sign_out_amisha  (sign_out),
        .exp_out_amisha   (exp_out),
        .frac_out_amisha  (frac_out),
        .ovf_amisha       (ovf),
        .unf_amisha       (unf)
    );

    typedef struct {
        string             name;
        logic              s1;
        logic [EXP_W-1:0]  e1;
        logic [FRAC_W-1:0] f1;
        logic              s2;
        logic [EXP_W-1:0]  e2;
        logic [FRAC_W-1:0] f2;
        logic              xs;
        logic [EXP_W-1:0]  xe;
        logic [FRAC_W-1:0] xf;
        logic              xo;
        logic              xu;
    } vec_t;

    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string n, logic s1, logic [3:0] e1, logic [7:0] f1,
                                logic s2, logic [3:0] e2, logic [7:0] f2,
                                logic xs, logic [3:0] xe, logic [7:0] xf, logic xo, logic xu);
        vec_t v;
        v.name = n;
        v.s1 = s1; v.e1 = e1; v.f1 = f1;
        v.s2 = s2; v.e2 = e2; v.f2 = f2;
        v.xs = xs; v.xe = xe; v.xf = xf; v.xo = xo; v.xu = xu;
        return v;
    endfunction

    function automatic logic [31:0] pk(logic s, logic [3:0] e, logic [7:0] f, logic o, logic u);
        return {17'd0, s, e, f, o, u};
    endfunction

    function automatic logic [31:0] dut_res();
        return pk(sign_out, exp_out, frac_out, ovf, unf);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Called just after a rising edge; returns edges until out_valid is seen.
    task automatic send_and_wait(input vec_t v, output int lat);
        sign1 = v.s1; exp1 = v.e1; frac1 = v.f1;
        sign2 = v.s2; exp2 = v.e2; frac2 = v.f2;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        vec_t nv;
        logic [31:0] exp_q5[6];

        vecs[0]  = mk("t1_carry",     0, 3, 8'h80, 0, 3, 8'h80, 0, 4, 8'h80, 0, 0);
        vecs[1]  = mk("t2_cancel",    0, 5, 8'hC0, 1, 5, 8'hC0, 0, 0, 8'h00, 0, 0);
        vecs[2]  = mk("t2_underflow", 0, 1, 8'h80, 1, 1, 8'h81, 0, 0, 8'h00, 0, 1);
        vecs[3]  = mk("t3_overflow",  0, 15, 8'hFF, 0, 15, 8'hFF, 0, 15, 8'hFF, 1, 0);
`ifdef FP_ADDER_ROUND_EN
        vecs[4]  = mk("t4_round",     0, 8, 8'h80, 0, 0, 8'hC0, 0, 8, 8'h81, 0, 0);
        vecs[10] = mk("tie_odd",      0, 8, 8'h81, 0, 0, 8'h80, 0, 8, 8'h82, 0, 0);
        vecs[12] = mk("rnd_ovf",      0, 15, 8'hFF, 0, 7, 8'h80, 0, 15, 8'hFF, 1, 0);
`else
        vecs[4]  = mk("t4_round",     0, 8, 8'h80, 0, 0, 8'hC0, 0, 8, 8'h80, 0, 0);
        vecs[10] = mk("tie_odd",      0, 8, 8'h81, 0, 0, 8'h80, 0, 8, 8'h81, 0, 0);
        vecs[12] = mk("rnd_ovf",      0, 15, 8'hFF, 0, 7, 8'h80, 0, 15, 8'hFF, 0, 0);
`endif
        vecs[5]  = mk("sub_norm",     0, 4, 8'h80, 1, 3, 8'h80, 0, 3, 8'h80, 0, 0);
        vecs[6]  = mk("neg_result",   1, 6, 8'hA0, 0, 6, 8'h90, 1, 3, 8'h80, 0, 0);
        vecs[7]  = mk("zero_zero",    0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[8]  = mk("zero_plus_neg",0, 0, 8'h00, 1, 5, 8'hB3, 1, 5, 8'hB3, 0, 0);
        vecs[9]  = mk("tie_even",     0, 8, 8'h80, 0, 0, 8'h80, 0, 8, 8'h80, 0, 0);
        vecs[11] = mk("far_sticky",   0, 15, 8'h80, 0, 0, 8'h80, 0, 15, 8'h80, 0, 0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sign1 = 1'b0; sign2 = 1'b0; exp1 = '0; exp2 = '0; frac1 = '0; frac2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", dut_res(), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            send_and_wait(vecs[i], lat);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(PIPE_DEPTH));
            chk(vecs[i].name, dut_res(),
                pk(vecs[i].xs, vecs[i].xe, vecs[i].xf, vecs[i].xo, vecs[i].xu));
            @(posedge clk); #1;
        end

        // Six back-to-back pairs with a three-cycle output stall.
        for (int i = 0; i < 6; i++) begin
            exp_q5[i] = pk(1'b0, 4'(i + 2), 8'h80, 1'b0, 1'b0);
        end
        fork
            begin
                bit acc;
                int tries;
                for (int i = 0; i < 6; i++) begin
                    sign1 = 1'b0; exp1 = 4'(i + 1); frac1 = 8'h80;
                    sign2 = 1'b0; exp2 = 4'(i + 1); frac2 = 8'h80;
                    in_valid = 1'b1;
                    tries = 0;
                    do begin
                        @(negedge clk); #2;
                        acc = in_ready;
                        @(posedge clk); #1;
                        tries++;
                    end while (!acc && tries < 20);
                    if (!acc) chk("t5_accept_timeout", 32'd0, 32'd1);
                end
                in_valid = 1'b0;
            end
            begin
                int got, cyc, stall;
                bit seen;
                got = 0; cyc = 0; stall = 0; seen = 1'b0;
                while (got < 6 && cyc < 80) begin
                    @(negedge clk);
                    cyc++;
                    if (!seen && out_valid) begin
                        seen = 1'b1; out_ready = 1'b0; stall = 3;
                    end else if (seen && stall == 0 && !out_ready) begin
                        out_ready = 1'b1;
                    end
                    #1;
                    if (stall > 0) begin
                        chk("t5_stall_in_ready", 32'(in_ready), 32'd0);
                        chk("t5_stall_out_valid", 32'(out_valid), 32'd1);
                        stall--;
                    end else if (out_valid && out_ready) begin
                        chk("t5_result_order", dut_res(), exp_q5[got]);
                        got++;
                    end
                end
                chk("t5_result_count", 32'(got), 32'd6);
            end
        join
        begin
            int extra;
            extra = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            chk("t5_no_duplicate", 32'(extra), 32'd0);
        end

        // Reset with three pairs in flight, then one fresh pair.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sign1 = 1'b0; exp1 = 4'd1; frac1 = 8'h80;
            sign2 = 1'b0; exp2 = 4'd1; frac2 = 8'h80;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv = mk("t6_new_pair", 0, 2, 8'hC0, 0, 2, 8'hC0, 0, 3, 8'hC0, 0, 0);
        send_and_wait(nv, lat);
        chk("t6_latency", 32'(lat), 32'(PIPE_DEPTH));
        chk("t6_new_pair", dut_res(), pk(nv.xs, nv.xe, nv.xf, nv.xo, nv.xu));
        @(posedge clk); #1;
        chk("t6_single_result", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
